// File: rtl/brlite_svc_queue.sv
// Receive-side FIFO that captures BrLite service packets from the router and presents the head to the NI.
// Optional macro BRLITE_SVC_DROP_EN: discard and count packets that arrive while full instead of stalling.
package brlite_svc_pkg;
    typedef struct packed {
        logic [7:0]  ksvc;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_svc_t;
endpackage

module brlite_svc_queue
    import brlite_svc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_req_i,
    output logic              rx_ack_o,
    input  logic [7:0]        rx_ksvc_i,
    input  logic [15:0]       rx_seq_source_i,
    input  logic [15:0]       rx_producer_i,
    input  logic [31:0]       rx_payload_i,
    output logic              br_svc_rx_o,
    output brlite_svc_t       br_svc_data_o,
    input  logic              br_svc_ack_i,
    output logic [PTR_W:0]    count_o,
    output logic [15:0]       drop_cnt_o
);
    brlite_svc_t      mem [DEPTH];
    brlite_svc_t      wr_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             offer;
    logic             push;
    logic             pop;
    logic             ack_next;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    // The ack gate stops a held request from being captured twice while the router lowers it.
    assign offer = rx_req_i && !rx_ack_o;
    assign push  = offer && !full;
    assign pop   = br_svc_ack_i && !empty;

    assign wr_entry = '{ksvc:       rx_ksvc_i,
                        seq_source: rx_seq_source_i,
                        producer:   rx_producer_i,
                        payload:    rx_payload_i};

`ifdef BRLITE_SVC_DROP_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop     = offer && full;
    assign ack_next = push || drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign ack_next   = push;
    assign drop_cnt_o = '0;
`endif

    // NOTE: the storage array is reset like any other register so the head reads zero after reset;
    // its writes use non-blocking assignments so the same edge sees the pre-edge pointers everywhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ack_o <= 1'b0;
        end else begin
            rx_ack_o <= ack_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign br_svc_rx_o   = !empty;
    assign br_svc_data_o = mem[rd_ptr];
    assign count_o       = count;

endmodule
